cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
//  Control unit driving the 8-bit/19-bit-instruction datapath: decodes command = instr[18:14] with C/Z flags into all datapath selects and enables.
//  Multi-cycle sequencer: boot cycle, single-cycle ALU/branch, LOAD_WAIT-stretched loads, call-stack depth tracking, HALT on error.
//  Adds pc_en; the datapath PC register loads only when pc_en=1.
// PARAMETERS
//  STACK_DEPTH  8  call-stack entries tracked; must match datapath stack
//  LOAD_WAIT    1  extra cycles (0..3) a LOAD holds PC before register write
// PORTS
//  clk           in   1  clock, rising edge
//  rst           in   1  reset, asynchronous, active-high
//  command       in   5  opcode, instr[18:14]
//  C_out, Z_out  in   1  carry / zero flags from datapath
//  sel_imm       out  1  ALU B = immediate instr[7:0]
//  store         out  1  data-memory write
//  en            out  1  C/Z flag update enable
//  pop, push     out  1  stack controls
//  sh_o_ALU      out  1  flag source: 1=shifter, 0=ALU
//  R2_o_Rd       out  1  second-register select = Rd (store)
//  regWrite      out  1  register-file write
//  pc_state      out  2  next-PC: 0=PC+1 1=stack 2=instr[11:0] 3=PC+sext(imm8)
//  what_the_faz  out  2  writeback: 0=ALU 1=memory 2=shifter
//  pc_en         out  1  PC load enable
//  halted        out  1  in S_HALT
//  err           out  2  0=none 1=illegal opcode 2=stack overflow 3=underflow
// BEHAVIOUR
//  Opcodes: 00fff ALU reg (fn=fff); 01fff ALU imm (sel_imm=1); 110ff shift (fn=ff);
//   10000 LOAD, 10001 STORE, 10010 JMP, 10011 CALL, 10100 RET, 10101 BZ, 10110 BNZ,
//   10111 BC, 11100 BNC, 11101 NOP, 11110 HALT, 11111 illegal.
//  States: S_BOOT -> S_RUN; S_RUN -LOAD & LOAD_WAIT>0-> S_LOAD; S_LOAD -wait_cnt==0-> S_RUN;
//   S_RUN -HALT/illegal/stack error-> S_HALT; S_HALT exited only by rst.
//  Reset (async): state=S_BOOT, depth=0, wait_cnt=0, err=0; all outputs 0 incl. pc_en.
//  S_BOOT: one cycle, all outputs 0 (PC holds at 0, no writes).
//  S_RUN default pc_en=1, pc_state=0; all enables 0 unless listed:
//   ALU reg/imm: regWrite=1, en=1, what_the_faz=0, sh_o_ALU=0.
//   shift: regWrite=1, en=1, what_the_faz=2, sh_o_ALU=1.
//   STORE: store=1, R2_o_Rd=1. JMP: pc_state=2.
//   CALL: push=1, pc_state=2, depth++. RET: pop=1, pc_state=1, depth--.
//   BZ/BNZ/BC/BNC: pc_state=3 when Z=1/Z=0/C=1/C=0, else 0; flags sampled same cycle.
//   NOP: PC+1 only. HALT: pc_en=0, enter S_HALT, err unchanged.
//  LOAD: LOAD_WAIT=0: regWrite=1, what_the_faz=1, pc_en=1 in one cycle.
//   LOAD_WAIT>0: S_RUN cycle pc_en=0, no writes, wait_cnt=LOAD_WAIT-1, go S_LOAD;
//   S_LOAD: pc_en=0 while wait_cnt>0 (decrement); at 0 regWrite=1, what_the_faz=1, pc_en=1.
//   Total LOAD latency LOAD_WAIT+1 cycles; command held stable (PC frozen).
//  Stack: CALL at depth==STACK_DEPTH -> no push, pc_en=0, err=2, S_HALT.
//   RET at depth==0 -> no pop, pc_en=0, err=3, S_HALT. Illegal -> pc_en=0, err=1, S_HALT.
//  S_HALT: all outputs 0 except halted=1; err sticky until rst.
//  Reset mid-LOAD or mid-anything: immediate return to reset values, no partial write.
//  depth width = $clog2(STACK_DEPTH+1); never wraps.
// STRUCTURE
//  cpu_ctrl_pkg: opcode localparams, state_t enum, pc_sel_t {PC_INC,PC_STK,PC_ABS,PC_REL},
//   wb_sel_t {WB_ALU,WB_MEM,WB_SHF}, err_t.
//  Sub-module cpu_ctrl_decode: combinational opcode+flags -> control word; top holds FSM,
//   depth counter, wait counter and error/halt gating.
// TESTING
//  Reset, command=00001: cycle1 all outputs 0 (S_BOOT); cycle2 regWrite=1, en=1, pc_en=1.
//  LOAD_WAIT=2, command=10000: pc_en=0,0, then regWrite=1, what_the_faz=1, pc_en=1.
//  BZ with Z=1 -> pc_state=3; Z=0 -> pc_state=0; BC with C=1 -> 3; BNC with C=1 -> 0.
//  9 consecutive CALLs (depth 8): first 8 push=1, 9th push=0, err=2, halted=1.
//  RET after reset -> pop=0, err=3, halted=1; stays halted under any command until rst.
//  command=11111 -> err=1, halted=1; rst asserted mid-S_LOAD -> outputs 0 immediately.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the CPU control unit:
//   - opcode localparams for the 5-bit command field (instr[18:14])
//   - sequencer state enum
//   - next-PC and writeback select enums
//   - error code enum
//   - the decoded control word passed from the decoder to the top level
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LOAD    = 5'b10000;
    localparam logic [4:0] OP_STORE   = 5'b10001;
    localparam logic [4:0] OP_JMP     = 5'b10010;
    localparam logic [4:0] OP_CALL    = 5'b10011;
    localparam logic [4:0] OP_RET     = 5'b10100;
    localparam logic [4:0] OP_BZ      = 5'b10101;
    localparam logic [4:0] OP_BNZ     = 5'b10110;
    localparam logic [4:0] OP_BC      = 5'b10111;
    localparam logic [4:0] OP_BNC     = 5'b11100;
    localparam logic [4:0] OP_NOP     = 5'b11101;
    localparam logic [4:0] OP_HALT    = 5'b11110;
    localparam logic [4:0] OP_ILLEGAL = 5'b11111;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_LOAD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PC_INC = 2'd0,
        PC_STK = 2'd1,
        PC_ABS = 2'd2,
        PC_REL = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_SHF = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_ILLEGAL   = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_UNDERFLOW = 2'd3
    } err_t;

    // Raw decode of one opcode; the top level decides whether it is
    // actually allowed to reach the datapath this cycle.
    typedef struct packed {
        logic    sel_imm;
        logic    store;
        logic    en;
        logic    pop;
        logic    push;
        logic    sh_o_ALU;
        logic    R2_o_Rd;
        logic    regWrite;
        pc_sel_t pc_state;
        wb_sel_t wb;
        logic    is_load;
        logic    is_call;
        logic    is_ret;
        logic    is_halt;
        logic    is_illegal;
    } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode
// Purely combinational opcode decoder. Turns the 5-bit command plus the
// C/Z flags into a control word. Sequencing, stack checks and halt gating
// are applied by cpu_controller, not here.
// Ports:
//   command  in   5  opcode, instr[18:14]
//   C_out    in   1  carry flag
//   Z_out    in   1  zero flag
//   ctrl     out     decoded control word (ctrl_t)
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] command,
    input  logic       C_out,
    input  logic       Z_out,
    output ctrl_t      ctrl
);

    // Branches pick the relative target only when their flag condition
    // holds; otherwise they fall through as PC+1.
    always_comb begin
        ctrl = '0;
        casez (command)
            5'b00???: begin
                ctrl.regWrite = 1'b1;
                ctrl.en       = 1'b1;
            end
            5'b01???: begin
                ctrl.regWrite = 1'b1;
                ctrl.en       = 1'b1;
                ctrl.sel_imm  = 1'b1;
            end
            5'b110??: begin
                ctrl.regWrite = 1'b1;
                ctrl.en       = 1'b1;
                ctrl.sh_o_ALU = 1'b1;
                ctrl.wb       = WB_SHF;
            end
            OP_LOAD: begin
                ctrl.is_load  = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.wb       = WB_MEM;
            end
            OP_STORE: begin
                ctrl.store   = 1'b1;
                ctrl.R2_o_Rd = 1'b1;
            end
            OP_JMP: begin
                ctrl.pc_state = PC_ABS;
            end
            OP_CALL: begin
                ctrl.is_call  = 1'b1;
                ctrl.push     = 1'b1;
                ctrl.pc_state = PC_ABS;
            end
            OP_RET: begin
                ctrl.is_ret   = 1'b1;
                ctrl.pop      = 1'b1;
                ctrl.pc_state = PC_STK;
            end
            OP_BZ: begin
                ctrl.pc_state = Z_out ? PC_REL : PC_INC;
            end
            OP_BNZ: begin
                ctrl.pc_state = Z_out ? PC_INC : PC_REL;
            end
            OP_BC: begin
                ctrl.pc_state = C_out ? PC_REL : PC_INC;
            end
            OP_BNC: begin
                ctrl.pc_state = C_out ? PC_INC : PC_REL;
            end
            OP_NOP: begin
            end
            OP_HALT: begin
                ctrl.is_halt = 1'b1;
            end
            OP_ILLEGAL: begin
                ctrl.is_illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller
// Multi-cycle control unit for the 8-bit / 19-bit-instruction datapath.
// Holds the sequencer FSM (boot, run, stretched load, halt), the call-stack
// depth counter, the load wait counter and the sticky error code, and gates
// the decoder's control word accordingly.
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   command   in 5  opcode instr[18:14]
//   C_out     in 1  carry flag      Z_out in 1  zero flag
//   sel_imm, store, en, pop, push, sh_o_ALU, R2_o_Rd, regWrite  out 1
//   pc_state  out 2 next-PC select  what_the_faz out 2 writeback select
//   pc_en     out 1 PC load enable  halted out 1 in S_HALT
//   err       out 2 sticky error code
module cpu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int LOAD_WAIT   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] command,
    input  logic       C_out,
    input  logic       Z_out,
    output logic       sel_imm,
    output logic       store,
    output logic       en,
    output logic       pop,
    output logic       push,
    output logic       sh_o_ALU,
    output logic       R2_o_Rd,
    output logic       regWrite,
    output logic [1:0] pc_state,
    output logic [1:0] what_the_faz,
    output logic       pc_en,
    output logic       halted,
    output logic [1:0] err
);

    localparam int             DW           = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0]  DEPTH_MAX    = DW'(STACK_DEPTH);
    localparam logic [1:0]     WAIT_INIT    = 2'(LOAD_WAIT - 1);
    localparam bit             LOAD_STRETCH = (LOAD_WAIT > 0);

    state_t        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [1:0]    wait_q, wait_d;
    err_t          err_q, err_d;
    ctrl_t         ctrl;

    logic stack_full;
    logic stack_empty;
    logic call_overflow;
    logic ret_underflow;
    logic run_blocked;

    cpu_ctrl_decode u_decode (
        .command (command),
        .C_out   (C_out),
        .Z_out   (Z_out),
        .ctrl    (ctrl)
    );

    assign stack_full    = (depth_q == DEPTH_MAX);
    assign stack_empty   = (depth_q == '0);
    assign call_overflow = ctrl.is_call && stack_full;
    assign ret_underflow = ctrl.is_ret && stack_empty;

    // Any S_RUN cycle that must not touch the datapath: stopping opcodes,
    // stack faults, and the first cycle of a stretched load.
    assign run_blocked = ctrl.is_halt || ctrl.is_illegal || call_overflow ||
                         ret_underflow || (ctrl.is_load && LOAD_STRETCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            depth_q <= '0;
            wait_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Stack faults are detected before the counter moves, so depth never
    // wraps past either end.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (ctrl.is_illegal) begin
                    err_d   = ERR_ILLEGAL;
                    state_d = S_HALT;
                end else if (ctrl.is_halt) begin
                    state_d = S_HALT;
                end else if (call_overflow) begin
                    err_d   = ERR_OVERFLOW;
                    state_d = S_HALT;
                end else if (ret_underflow) begin
                    err_d   = ERR_UNDERFLOW;
                    state_d = S_HALT;
                end else if (ctrl.is_call) begin
                    depth_d = depth_q + DW'(1);
                end else if (ctrl.is_ret) begin
                    depth_d = depth_q - DW'(1);
                end else if (ctrl.is_load && LOAD_STRETCH) begin
                    wait_d  = WAIT_INIT;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (wait_q != 2'd0) begin
                    wait_d = wait_q - 2'd1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Everything defaults to 0 so S_BOOT, S_HALT and blocked cycles leave the
    // datapath frozen; only err and halted escape that default.
    always_comb begin
        sel_imm      = 1'b0;
        store        = 1'b0;
        en           = 1'b0;
        pop          = 1'b0;
        push         = 1'b0;
        sh_o_ALU     = 1'b0;
        R2_o_Rd      = 1'b0;
        regWrite     = 1'b0;
        pc_state     = PC_INC;
        what_the_faz = WB_ALU;
        pc_en        = 1'b0;
        halted       = (state_q == S_HALT);
        err          = err_q;
        case (state_q)
            S_RUN: begin
                if (!run_blocked) begin
                    sel_imm      = ctrl.sel_imm;
                    store        = ctrl.store;
                    en           = ctrl.en;
                    pop          = ctrl.pop;
                    push         = ctrl.push;
                    sh_o_ALU     = ctrl.sh_o_ALU;
                    R2_o_Rd      = ctrl.R2_o_Rd;
                    regWrite     = ctrl.regWrite;
                    pc_state     = ctrl.pc_state;
                    what_the_faz = ctrl.wb;
                    pc_en        = 1'b1;
                end
            end
            S_LOAD: begin
                if (wait_q == 2'd0) begin
                    regWrite     = 1'b1;
                    what_the_faz = WB_MEM;
                    pc_en        = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller
// Directed and randomized stimulus for cpu_controller (STACK_DEPTH=8,
// LOAD_WAIT=2), checked against a behavioural model of the instruction set.
module tb_cpu_controller;

    localparam int SD = 8;
    localparam int LW = 2;

    typedef struct packed {
        logic       sel_imm;
        logic       store;
        logic       en;
        logic       pop;
        logic       push;
        logic       sh;
        logic       r2;
        logic       rw;
        logic [1:0] pcs;
        logic [1:0] wb;
        logic       pc_en;
        logic       halted;
        logic [1:0] err;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] command = 5'd0;
    logic       C_out = 1'b0;
    logic       Z_out = 1'b0;
    logic       sel_imm, store, en, pop, push, sh_o_ALU, R2_o_Rd, regWrite;
    logic [1:0] pc_state, what_the_faz, err;
    logic       pc_en, halted;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_boot;
    bit m_halt;
    int m_left;
    int m_depth;
    int m_err;

    cpu_controller #(.STACK_DEPTH(SD), .LOAD_WAIT(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .command      (command),
        .C_out        (C_out),
        .Z_out        (Z_out),
        .sel_imm      (sel_imm),
        .store        (store),
        .en           (en),
        .pop          (pop),
        .push         (push),
        .sh_o_ALU     (sh_o_ALU),
        .R2_o_Rd      (R2_o_Rd),
        .regWrite     (regWrite),
        .pc_state     (pc_state),
        .what_the_faz (what_the_faz),
        .pc_en        (pc_en),
        .halted       (halted),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        m_boot  = 1'b1;
        m_halt  = 1'b0;
        m_left  = -1;
        m_depth = 0;
        m_err   = 0;
    endtask

    // One instruction cycle of the model: returns the expected outputs for
    // this cycle and advances the model across the following clock edge.
    task automatic modelStep(input logic [4:0] cmd, input logic c, input logic z,
                             output outs_t e);
        int op;
        op = int'(cmd);
        e = '0;
        e.err = 2'(m_err);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            e.halted = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
        end else if (m_left == 0) begin
            e.rw = 1'b1; e.wb = 2'd1; e.pc_en = 1'b1;
            m_left = -1;
        end else begin
            e.pc_en = 1'b1;
            if (op < 16) begin
                e.rw = 1'b1; e.en = 1'b1; e.sel_imm = (op >= 8);
            end else if (op >= 24 && op <= 27) begin
                e.rw = 1'b1; e.en = 1'b1; e.sh = 1'b1; e.wb = 2'd2;
            end else begin
                case (op)
                    16: begin
                        if (LW == 0) begin
                            e.rw = 1'b1; e.wb = 2'd1;
                        end else begin
                            e.pc_en = 1'b0;
                            m_left = LW - 1;
                        end
                    end
                    17: begin e.store = 1'b1; e.r2 = 1'b1; end
                    18: e.pcs = 2'd2;
                    19: begin
                        if (m_depth == SD) begin
                            e.pc_en = 1'b0; m_err = 2; m_halt = 1'b1;
                        end else begin
                            e.push = 1'b1; e.pcs = 2'd2; m_depth++;
                        end
                    end
                    20: begin
                        if (m_depth == 0) begin
                            e.pc_en = 1'b0; m_err = 3; m_halt = 1'b1;
                        end else begin
                            e.pop = 1'b1; e.pcs = 2'd1; m_depth--;
                        end
                    end
                    21: e.pcs = z ? 2'd3 : 2'd0;
                    22: e.pcs = z ? 2'd0 : 2'd3;
                    23: e.pcs = c ? 2'd3 : 2'd0;
                    28: e.pcs = c ? 2'd0 : 2'd3;
                    30: begin e.pc_en = 1'b0; m_halt = 1'b1; end
                    31: begin e.pc_en = 1'b0; m_err = 1; m_halt = 1'b1; end
                    default: begin end
                endcase
            end
        end
    endtask

    task automatic checkOutput(input string tag, input outs_t exp_v);
        outs_t obs;
        obs = {sel_imm, store, en, pop, push, sh_o_ALU, R2_o_Rd, regWrite,
               pc_state, what_the_faz, pc_en, halted, err};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic applyStimulus(input string tag, input logic [4:0] cmd,
                                 input logic c, input logic z);
        outs_t e;
        command = cmd;
        C_out   = c;
        Z_out   = z;
        #2;
        modelStep(cmd, c, z, e);
        checkOutput(tag, e);
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("reset", '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] rc;
        int         r;

        $display("[TB] start");
        doReset();

        // Boot cycle then first ALU op
        applyStimulus("boot", 5'b00001, 1'b0, 1'b0);
        applyStimulus("alu_reg", 5'b00001, 1'b0, 1'b0);
        applyStimulus("alu_imm", 5'b01010, 1'b0, 1'b0);
        applyStimulus("shift", 5'b11010, 1'b0, 1'b0);

        // Stretched load: two frozen cycles then the write
        applyStimulus("load_c0", 5'b10000, 1'b0, 1'b0);
        applyStimulus("load_c1", 5'b10000, 1'b0, 1'b0);
        applyStimulus("load_c2", 5'b10000, 1'b0, 1'b0);

        // Branches
        applyStimulus("bz_taken", 5'b10101, 1'b0, 1'b1);
        applyStimulus("bz_not", 5'b10101, 1'b0, 1'b0);
        applyStimulus("bc_taken", 5'b10111, 1'b1, 1'b0);
        applyStimulus("bnc_not", 5'b11100, 1'b1, 1'b0);
        applyStimulus("store", 5'b10001, 1'b0, 1'b0);

        // Stack overflow on the ninth CALL
        for (int i = 0; i < 9; i++) applyStimulus("call", 5'b10011, 1'b0, 1'b0);
        applyStimulus("after_overflow", 5'b00000, 1'b0, 1'b0);

        // Underflow straight after reset, then stays halted
        doReset();
        applyStimulus("boot2", 5'b10100, 1'b0, 1'b0);
        applyStimulus("ret_underflow", 5'b10100, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus("halt_hold", 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));

        // Illegal opcode
        doReset();
        applyStimulus("boot3", 5'b11111, 1'b0, 1'b0);
        applyStimulus("illegal", 5'b11111, 1'b0, 1'b0);
        applyStimulus("illegal_halted", 5'b00000, 1'b0, 1'b0);

        // Reset while in S_LOAD
        doReset();
        applyStimulus("boot4", 5'b10000, 1'b0, 1'b0);
        applyStimulus("load_start", 5'b10000, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("reset_mid_load", '0);
        doReset();

        // Randomized runs
        for (int round = 0; round < 4; round++) begin
            doReset();
            for (int n = 0; n < 80; n++) begin
                if (m_left >= 0) begin
                    rc = 5'b10000;
                end else begin
                    r = int'($urandom_range(0, 99));
                    rc = (r < 3) ? 5'(30 + $urandom_range(0, 1)) : 5'($urandom_range(0, 29));
                end
                applyStimulus("rand", rc, 1'($urandom), 1'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
